// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the Simple RISC Machine controller: instruction fields,
// state codes and the one-hot / command values driven onto the datapath.
package cpu_defs;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // ALU and ALU_Z are the same step; ALU_Z zeroes the A operand (MOV reg, MVN)
  // so asel stays a pure function of the state register.
  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_IF1     = 5'd1,
    S_IF2     = 5'd2,
    S_UPD_PC  = 5'd3,
    S_DECODE  = 5'd4,
    S_WR_IMM  = 5'd5,
    S_GET_A   = 5'd6,
    S_GET_B   = 5'd7,
    S_ALU     = 5'd8,
    S_ALU_Z   = 5'd9,
    S_CMP     = 5'd10,
    S_WR_RD   = 5'd11,
    S_ADDR    = 5'd12,
    S_LD_ADDR = 5'd13,
    S_MEM_RD1 = 5'd14,
    S_MEM_RD2 = 5'd15,
    S_GET_BD  = 5'd16,
    S_STR_C   = 5'd17,
    S_MEM_WR  = 5'd18,
    S_HALT    = 5'd19
  } state_e;

endpackage

// File: rtl/cpu_controller_if.sv
// Decoder-to-controller inputs and controller-to-datapath/memory controls.
interface cpu_controller_if;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       halted;

  modport master (
    input  opcode, op,
    output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );

  modport slave (
    output opcode, op,
    input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );

endinterface

// File: rtl/cpu_controller.sv
// Moore sequencer for the Simple RISC Machine: fetch, PC update, decode and
// per-instruction datapath/memory control. Outputs decode the state register only.
module cpu_controller
  import cpu_defs::*;
#(
  parameter int STATE_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  logic [4:0]         ins;

  assign ins = {bus.opcode, bus.op};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STATE_W'(S_RST);
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = STATE_W'(S_RST);
    bus.nsel      = NSEL_NONE;
    bus.vsel      = 4'b0000;
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.load_addr = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.halted    = 1'b0;

    case (state)
      STATE_W'(S_RST): begin
        bus.reset_pc = 1'b1;
        bus.load_pc  = 1'b1;
        state_nx     = STATE_W'(S_IF1);
      end
      STATE_W'(S_IF1): begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MEM_READ;
        state_nx     = STATE_W'(S_IF2);
      end
      STATE_W'(S_IF2): begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MEM_READ;
        bus.load_ir  = 1'b1;
        state_nx     = STATE_W'(S_UPD_PC);
      end
      STATE_W'(S_UPD_PC): begin
        bus.load_pc = 1'b1;
        state_nx    = STATE_W'(S_DECODE);
      end
      STATE_W'(S_DECODE): begin
        case (ins)
          {OPC_MOV, OP_MOV_IMM}:                    state_nx = STATE_W'(S_WR_IMM);
          {OPC_MOV, OP_MOV_REG}, {OPC_ALU, OP_MVN}: state_nx = STATE_W'(S_GET_B);
          {OPC_ALU, OP_ADD}, {OPC_ALU, OP_CMP}, {OPC_ALU, OP_AND},
          {OPC_LDR, OP_MEM}, {OPC_STR, OP_MEM}:     state_nx = STATE_W'(S_GET_A);
          default:
            state_nx = (bus.opcode == OPC_HALT) ? STATE_W'(S_HALT) : STATE_W'(S_IF1);
        endcase
      end
      STATE_W'(S_WR_IMM): begin
        bus.nsel  = NSEL_RN;
        bus.vsel  = VSEL_SXIMM8;
        bus.write = 1'b1;
        state_nx  = STATE_W'(S_IF1);
      end
      STATE_W'(S_GET_A): begin
        bus.nsel  = NSEL_RN;
        bus.loada = 1'b1;
        state_nx  = (bus.opcode == OPC_ALU) ? STATE_W'(S_GET_B) : STATE_W'(S_ADDR);
      end
      STATE_W'(S_GET_B): begin
        bus.nsel  = NSEL_RM;
        bus.loadb = 1'b1;
        if (ins == {OPC_ALU, OP_CMP})
          state_nx = STATE_W'(S_CMP);
        else if (ins == {OPC_MOV, OP_MOV_REG} || ins == {OPC_ALU, OP_MVN})
          state_nx = STATE_W'(S_ALU_Z);
        else
          state_nx = STATE_W'(S_ALU);
      end
      STATE_W'(S_ALU): begin
        bus.loadc = 1'b1;
        state_nx  = STATE_W'(S_WR_RD);
      end
      STATE_W'(S_ALU_Z): begin
        bus.asel  = 1'b1;
        bus.loadc = 1'b1;
        state_nx  = STATE_W'(S_WR_RD);
      end
      STATE_W'(S_CMP): begin
        bus.loads = 1'b1;
        state_nx  = STATE_W'(S_IF1);
      end
      STATE_W'(S_WR_RD): begin
        bus.nsel  = NSEL_RD;
        bus.vsel  = VSEL_C;
        bus.write = 1'b1;
        state_nx  = STATE_W'(S_IF1);
      end
      STATE_W'(S_ADDR): begin
        bus.bsel  = 1'b1;
        bus.loadc = 1'b1;
        state_nx  = STATE_W'(S_LD_ADDR);
      end
      STATE_W'(S_LD_ADDR): begin
        bus.load_addr = 1'b1;
        state_nx      = (bus.opcode == OPC_LDR) ? STATE_W'(S_MEM_RD1) : STATE_W'(S_GET_BD);
      end
      STATE_W'(S_MEM_RD1): begin
        bus.mem_cmd = MEM_READ;
        state_nx    = STATE_W'(S_MEM_RD2);
      end
      STATE_W'(S_MEM_RD2): begin
        bus.mem_cmd = MEM_READ;
        bus.nsel    = NSEL_RD;
        bus.vsel    = VSEL_MDATA;
        bus.write   = 1'b1;
        state_nx    = STATE_W'(S_IF1);
      end
      STATE_W'(S_GET_BD): begin
        bus.nsel  = NSEL_RD;
        bus.loadb = 1'b1;
        state_nx  = STATE_W'(S_STR_C);
      end
      STATE_W'(S_STR_C): begin
        bus.asel  = 1'b1;
        bus.loadc = 1'b1;
        state_nx  = STATE_W'(S_MEM_WR);
      end
      STATE_W'(S_MEM_WR): begin
        bus.mem_cmd = MEM_WRITE;
        state_nx    = STATE_W'(S_IF1);
      end
      STATE_W'(S_HALT): begin
        bus.halted = 1'b1;
        state_nx   = STATE_W'(S_HALT);
      end
      default: state_nx = STATE_W'(S_RST);
    endcase
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Moore state machine that sequences the Simple RISC Machine datapath and its instruction memory interface.
- Fetches each instruction, advances the PC and decodes opcode/op.
- Drives every register-file, pipeline-register, mux and memory control for one instruction at a time.
- Sits between the instruction register/decoder and the datapath. ALUop and shift come straight from the decoder, not from this block.

Parameters:
STATE_W, 5, width of the state register (must hold all states listed below)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  3  instruction bits [15:13] from the instruction register
op  in  2  instruction bits [12:11]
nsel  out  3  register select, one-hot: 100 Rn, 010 Rd, 001 Rm, 000 none
vsel  out  4  writeback select, one-hot: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
write  out  1  register-file write enable
loada, loadb, loadc, loads  out  1 each  datapath register enables
asel, bsel  out  1 each  asel=1 forces A to 0; bsel=1 selects sximm5
load_ir  out  1  instruction-register enable
load_pc  out  1  PC enable
reset_pc  out  1  PC next = 0 when 1, else PC+1
addr_sel  out  1  memory address: 1 PC, 0 data-address register
load_addr  out  1  data-address register enable (loads C[8:0])
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
halted  out  1  high while in HALT

Behaviour:
- Pure Moore: outputs decode the state register only. Any output not listed for a state is 0.
- Async reset → state RST, regardless of current state (including mid-instruction or HALT).
- While reset is asserted, outputs are the RST outputs: reset_pc=1, load_pc=1, all others 0.

Fetch sequence:
- RST → IF1.
- IF1: addr_sel=1, mem_cmd=READ → IF2.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1 → UPD_PC.
- UPD_PC: load_pc=1 (reset_pc=0) → DECODE.
- DECODE: no outputs; branches on {opcode, op}:
  - 110_10 MOV imm → WR_IMM
  - 110_00 MOV reg → GET_B
  - 101_00 ADD, 101_01 CMP, 101_10 AND → GET_A
  - 101_11 MVN → GET_B
  - 011_00 LDR, 100_00 STR → GET_A
  - 111_xx → HALT
  - any other encoding → IF1 (NOP)

Execute states:
- WR_IMM: nsel=Rn, vsel=0100, write=1 → IF1.
- GET_A: nsel=Rn, loada=1 → GET_B for ALU ops; → ADDR for LDR/STR.
- GET_B: nsel=Rm, loadb=1 → ALU (asel=1 in ALU for MOV reg/MVN), or → CMP.
- ALU: loadc=1, asel per op, bsel=0 → WR_RD.
- CMP: loads=1, asel=0, bsel=0 → IF1 (no register write).
- WR_RD: nsel=Rd, vsel=0001, write=1 → IF1.
- ADDR: asel=0, bsel=1, loadc=1 → LD_ADDR.
- LD_ADDR: load_addr=1 → MEM_RD1 (LDR) or GET_BD (STR).
- MEM_RD1: addr_sel=0, mem_cmd=READ → MEM_RD2.
- MEM_RD2: addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=1000, write=1 → IF1.
- GET_BD: nsel=Rd, loadb=1 → STR_C.
- STR_C: asel=1, bsel=0, loadc=1 → MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=WRITE → IF1.
- HALT: halted=1; self-loop until reset.

Instruction latency, reset release to next IF1 counted from IF1:
- MOV imm 5 cycles.
- MOV reg, MVN, CMP 7 cycles.
- ADD, AND 8 cycles.
- LDR 9 cycles.
- STR 10 cycles.

Invariants:
- write and mem_cmd=WRITE are never both active.
- load_ir is active only in IF2.
- load_pc is active only in RST and UPD_PC.
- Unreachable state encodings → RST on the next edge.

Decomposition:
- Package cpu_defs holds:
  - opcode and op constants
  - state encodings (STATE_W wide)
  - MEM_NONE/READ/WRITE
  - VSEL_MDATA/SXIMM8/PC/C
  - NSEL_RN/RD/RM
- Single module: one always block for the async-reset state register, one combinational block for next-state and outputs. No sub-module.

Test Plan:
- Reset held 3 cycles then released → outputs reset_pc=1, load_pc=1 during reset. IF1 on the first edge after release, with addr_sel=1, mem_cmd=01.
- MOV imm (opcode=110, op=10) → WR_IMM on cycle 5 with nsel=100, vsel=0100, write=1; back in IF1 on cycle 6.
- ADD (101_00) → GET_A nsel=100 loada, GET_B nsel=001 loadb, ALU loadc, WR_RD nsel=010 vsel=0001 write; 8 cycles total. CMP (101_01) has loads=1, never write=1, and takes 7 cycles.
- LDR (011_00) → ADDR bsel=1 loadc, LD_ADDR load_addr, then MEM_RD1/RD2 with addr_sel=0, mem_cmd=01; write=1 with vsel=1000 in MEM_RD2.
- STR (100_00) → GET_BD nsel=010 loadb, STR_C asel=1, then MEM_WR mem_cmd=10, addr_sel=0, write=0; 10 cycles total.
- HALT (111) → halted=1 held for 20 cycles with all enables 0. Reset asserted mid-ADD (in GET_B) → RST immediately (asynchronous), then a normal fetch after release.
